// File: rtl/tcp_tab_rd_arb_pkg.sv
// ---------------------------------------------------------------------------
// tcp_tab_rd_arb_pkg
// Shared definitions for the TCP connection-table clients.
//   - Default table geometry (address/entry widths) and RAM read latency.
//   - Response word layout: {address, entry}. The entry sits in the low
//     TAB_DWID bits and the address sits directly above it.
//   - idx_width(): width of an index into an N-entry vector (minimum 1).
// ---------------------------------------------------------------------------
package tcp_tab_rd_arb_pkg;

  localparam int TCP_TAB_AWID   = 12;
  localparam int TCP_TAB_DWID   = 128;
  localparam int TCP_TAB_RD_LAT = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_tab_rd_arb_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Generic N-way round-robin arbiter. The grant goes to the first requesting
// index strictly after the pointer, searching modulo N. The pointer only
// moves, to the granted index, when the parent asserts upd.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointer -> N-1)
//   req        : request / eligible vector
//   upd        : grant was consumed this cycle, advance the pointer
//   gnt        : one-hot grant (zero when nothing requests)
//   gnt_vld    : at least one request present
//   gnt_idx    : binary index of the granted requester
// ---------------------------------------------------------------------------
import tcp_tab_rd_arb_pkg::*;

module rr_arb #(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after the pointer overwrites any earlier hit and wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (req[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd && gnt_vld) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(N-1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tcp_tab_rd_arb.sv
// ---------------------------------------------------------------------------
// tcp_tab_rd_arb
// Arbiter/sequencer for the single-port TCP connection-table RAM. Each cycle
// one slot is issued: either a CPU configuration write or a round-robin read
// grant to one of REQ_NUM request FIFOs. Reads flow through a fixed pipeline
// (S1 address capture, S2 registered RAM command, RD_LAT return shift) and
// the result is written to the originating requester's response FIFO.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_fifo_empty    : per-requester request FIFO empty
//   req_fifo_ren      : pop strobe (one-hot or zero)
//   req_fifo_rdata    : per-requester address, valid the cycle after ren
//   rsp_fifo_nafull   : per-requester response FIFO has room
//   rsp_fifo_wen      : response write strobe (one-hot or zero)
//   rsp_fifo_wdata    : {address, entry}, shared by all requesters
//   cfg_wen/waddr/wdata, cfg_wrdy : CPU write request and acceptance
//   tab_en/we/addr/wdata, tab_rdata : RAM port
//   dbg_sig           : [15:0] read grants, [31:16] writes accepted
// ---------------------------------------------------------------------------
import tcp_tab_rd_arb_pkg::*;

module tcp_tab_rd_arb #(
  parameter int REQ_NUM      = 3,
  parameter int TAB_AWID     = TCP_TAB_AWID,
  parameter int TAB_DWID     = TCP_TAB_DWID,
  parameter int RD_LAT       = TCP_TAB_RD_LAT,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_NUM-1:0]           req_fifo_empty,
  output logic [REQ_NUM-1:0]           req_fifo_ren,
  input  logic [REQ_NUM*TAB_AWID-1:0]  req_fifo_rdata,
  input  logic [REQ_NUM-1:0]           rsp_fifo_nafull,
  output logic [REQ_NUM-1:0]           rsp_fifo_wen,
  output logic [TAB_AWID+TAB_DWID-1:0] rsp_fifo_wdata,
  input  logic                         cfg_wen,
  input  logic [TAB_AWID-1:0]          cfg_waddr,
  input  logic [TAB_DWID-1:0]          cfg_wdata,
  output logic                         cfg_wrdy,
  output logic                         tab_en,
  output logic                         tab_we,
  output logic [TAB_AWID-1:0]          tab_addr,
  output logic [TAB_DWID-1:0]          tab_wdata,
  input  logic [TAB_DWID-1:0]          tab_rdata,
  output logic [31:0]                  dbg_sig
);

  localparam int IW = idx_width(REQ_NUM);
  localparam int BW = $clog2(WR_BURST_MAX + 1);

  // Slot decision
  logic [REQ_NUM-1:0] elig;
  logic [REQ_NUM-1:0] arb_gnt;
  logic               arb_vld;
  logic [IW-1:0]      arb_idx;
  logic               burst_full;
  logic               wr_acc;
  logic               rd_gnt;

  // Registers
  logic [BW-1:0]       wr_burst_cnt_q, wr_burst_cnt_d;
  logic                s1_vld_q, s1_vld_d;
  logic                s1_we_q, s1_we_d;
  logic [IW-1:0]       s1_idx_q, s1_idx_d;
  logic [TAB_AWID-1:0] s1_waddr_q, s1_waddr_d;
  logic [TAB_DWID-1:0] s1_wdata_q, s1_wdata_d;
  logic                tab_en_q, tab_en_d;
  logic                tab_we_q, tab_we_d;
  logic [IW-1:0]       tab_idx_q, tab_idx_d;
  logic [TAB_AWID-1:0] tab_addr_q, tab_addr_d;
  logic [TAB_DWID-1:0] tab_wdata_q, tab_wdata_d;
  logic [RD_LAT-1:0]                ret_vld_q, ret_vld_d;
  logic [RD_LAT-1:0][IW-1:0]        ret_idx_q, ret_idx_d;
  logic [RD_LAT-1:0][TAB_AWID-1:0]  ret_addr_q, ret_addr_d;
  logic [REQ_NUM-1:0]               rsp_wen_q, rsp_wen_d;
  logic [TAB_AWID+TAB_DWID-1:0]     rsp_wdata_q, rsp_wdata_d;
  logic [15:0]                      rd_cnt_q, rd_cnt_d;
  logic [15:0]                      wr_cnt_q, wr_cnt_d;
  logic [TAB_AWID-1:0]              rd_addr;

  assign elig       = ~req_fifo_empty & rsp_fifo_nafull;
  assign burst_full = (wr_burst_cnt_q == BW'(WR_BURST_MAX));

  // Writes are only throttled when a read is actually waiting for a slot.
  assign cfg_wrdy = ~(burst_full & (|elig));
  assign wr_acc   = cfg_wen & cfg_wrdy & ~rst;
  assign rd_gnt   = arb_vld & ~wr_acc & ~rst;

  rr_arb #(.N(REQ_NUM), .IW(IW)) u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (elig),
    .upd     (rd_gnt),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  assign req_fifo_ren = rd_gnt ? arb_gnt : '0;

  // S0 -> S1: capture the slot owner; read address arrives next cycle.
  always_comb begin
    wr_burst_cnt_d = '0;
    if (wr_acc) wr_burst_cnt_d = burst_full ? wr_burst_cnt_q : wr_burst_cnt_q + BW'(1);
    s1_vld_d   = wr_acc | rd_gnt;
    s1_we_d    = wr_acc;
    s1_idx_d   = arb_idx;
    s1_waddr_d = cfg_waddr;
    s1_wdata_d = cfg_wdata;
    rd_cnt_d   = rd_cnt_q + 16'(rd_gnt);
    wr_cnt_d   = wr_cnt_q + 16'(wr_acc);
  end

  // S1 -> S2: pick the popped address for reads and register the RAM command.
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (s1_idx_q == IW'(i)) rd_addr = req_fifo_rdata[i*TAB_AWID +: TAB_AWID];
    tab_en_d    = s1_vld_q;
    tab_we_d    = s1_vld_q & s1_we_q;
    tab_idx_d   = s1_idx_q;
    tab_addr_d  = '0;
    tab_wdata_d = '0;
    if (s1_vld_q) begin
      tab_addr_d  = s1_we_q ? s1_waddr_q : rd_addr;
      tab_wdata_d = s1_we_q ? s1_wdata_q : '0;
    end
  end

  // Return path: the last stage lines up with valid tab_rdata, and the
  // response is registered one cycle later.
  always_comb begin
    ret_vld_d     = '0;
    ret_idx_d     = '0;
    ret_addr_d    = '0;
    ret_vld_d[0]  = tab_en_q & ~tab_we_q;
    ret_idx_d[0]  = tab_idx_q;
    ret_addr_d[0] = tab_addr_q;
    for (int k = 1; k < RD_LAT; k++) begin
      ret_vld_d[k]  = ret_vld_q[k-1];
      ret_idx_d[k]  = ret_idx_q[k-1];
      ret_addr_d[k] = ret_addr_q[k-1];
    end
    rsp_wen_d   = '0;
    rsp_wdata_d = rsp_wdata_q;
    if (ret_vld_q[RD_LAT-1]) begin
      rsp_wen_d[ret_idx_q[RD_LAT-1]] = 1'b1;
      rsp_wdata_d = {ret_addr_q[RD_LAT-1], tab_rdata};
    end
  end

  // Reset discards every in-flight slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_burst_cnt_q <= '0;
      s1_vld_q       <= 1'b0;
      s1_we_q        <= 1'b0;
      s1_idx_q       <= '0;
      s1_waddr_q     <= '0;
      s1_wdata_q     <= '0;
      tab_en_q       <= 1'b0;
      tab_we_q       <= 1'b0;
      tab_idx_q      <= '0;
      tab_addr_q     <= '0;
      tab_wdata_q    <= '0;
      ret_vld_q      <= '0;
      ret_idx_q      <= '0;
      ret_addr_q     <= '0;
      rsp_wen_q      <= '0;
      rsp_wdata_q    <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
    end else begin
      wr_burst_cnt_q <= wr_burst_cnt_d;
      s1_vld_q       <= s1_vld_d;
      s1_we_q        <= s1_we_d;
      s1_idx_q       <= s1_idx_d;
      s1_waddr_q     <= s1_waddr_d;
      s1_wdata_q     <= s1_wdata_d;
      tab_en_q       <= tab_en_d;
      tab_we_q       <= tab_we_d;
      tab_idx_q      <= tab_idx_d;
      tab_addr_q     <= tab_addr_d;
      tab_wdata_q    <= tab_wdata_d;
      ret_vld_q      <= ret_vld_d;
      ret_idx_q      <= ret_idx_d;
      ret_addr_q     <= ret_addr_d;
      rsp_wen_q      <= rsp_wen_d;
      rsp_wdata_q    <= rsp_wdata_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
    end
  end

  assign tab_en         = tab_en_q;
  assign tab_we         = tab_we_q;
  assign tab_addr       = tab_addr_q;
  assign tab_wdata      = tab_wdata_q;
  assign rsp_fifo_wen   = rsp_wen_q;
  assign rsp_fifo_wdata = rsp_wdata_q;
  assign dbg_sig        = {wr_cnt_q, rd_cnt_q};

endmodule

// File: tb/tb_tcp_tab_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_tcp_tab_rd_arb
// Bench for tcp_tab_rd_arb: behavioural request FIFOs and table RAM, a
// response scoreboard fed in expected grant order, and directed scenarios.
// ---------------------------------------------------------------------------
module tb_tcp_tab_rd_arb;

  localparam int REQ_NUM = 3;
  localparam int AW      = 12;
  localparam int DW      = 128;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [REQ_NUM-1:0]    req_fifo_empty;
  logic [REQ_NUM-1:0]    req_fifo_ren;
  logic [REQ_NUM*AW-1:0] req_fifo_rdata;
  logic [REQ_NUM-1:0]    rsp_fifo_nafull = 3'b111;
  logic [REQ_NUM-1:0]    rsp_fifo_wen;
  logic [AW+DW-1:0]      rsp_fifo_wdata;
  logic                  cfg_wen = 1'b0;
  logic [AW-1:0]         cfg_waddr = '0;
  logic [DW-1:0]         cfg_wdata = '0;
  logic                  cfg_wrdy;
  logic                  tab_en;
  logic                  tab_we;
  logic [AW-1:0]         tab_addr;
  logic [DW-1:0]         tab_wdata;
  logic [DW-1:0]         tab_rdata;
  logic [31:0]           dbg_sig;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcp_tab_rd_arb #(
    .REQ_NUM(REQ_NUM), .TAB_AWID(AW), .TAB_DWID(DW), .RD_LAT(2), .WR_BURST_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_fifo_empty(req_fifo_empty), .req_fifo_ren(req_fifo_ren),
    .req_fifo_rdata(req_fifo_rdata), .rsp_fifo_nafull(rsp_fifo_nafull),
    .rsp_fifo_wen(rsp_fifo_wen), .rsp_fifo_wdata(rsp_fifo_wdata),
    .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_wrdy(cfg_wrdy), .tab_en(tab_en), .tab_we(tab_we),
    .tab_addr(tab_addr), .tab_wdata(tab_wdata), .tab_rdata(tab_rdata),
    .dbg_sig(dbg_sig)
  );

  // Request FIFO models: tail advanced by stimulus, head by pops.
  logic [AW-1:0] fmem [REQ_NUM][64];
  int            head [REQ_NUM] = '{0, 0, 0};
  int            tail [REQ_NUM] = '{0, 0, 0};
  logic [AW-1:0] rdata_r [REQ_NUM];

  always_comb
    for (int i = 0; i < REQ_NUM; i++) req_fifo_empty[i] = (head[i] == tail[i]);

  always @(posedge clk)
    for (int i = 0; i < REQ_NUM; i++)
      if (req_fifo_ren[i]) begin
        rdata_r[i] <= fmem[i][head[i] % 64];
        head[i]    <= head[i] + 1;
      end

  assign req_fifo_rdata = {rdata_r[2], rdata_r[1], rdata_r[0]};

  // Table RAM model: two-cycle read latency, writes visible to later slots.
  logic [DW-1:0] wmem [4096];
  bit            wvld [4096];
  logic [DW-1:0] rd_p0 = '0;
  logic [DW-1:0] rd_p1 = '0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [7:0] b;
    b = a[7:0] ^ 8'hF1;
    return {16{b}};
  endfunction

  always @(posedge clk) begin
    if (tab_en && tab_we) begin
      wmem[tab_addr] <= tab_wdata;
      wvld[tab_addr] <= 1'b1;
    end
    rd_p0 <= (tab_en && !tab_we) ? (wvld[tab_addr] ? wmem[tab_addr] : pat(tab_addr)) : '0;
    rd_p1 <= rd_p0;
  end

  assign tab_rdata = rd_p1;

  // Scoreboard of expected responses, in expected grant order.
  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  initial begin : monitor
    exp_t e;
    int   widx;
    forever begin
      @(negedge clk);
      if (rsp_fifo_wen !== '0) begin
        widx = -1;
        for (int i = 0; i < REQ_NUM; i++) if (rsp_fifo_wen[i] === 1'b1) widx = i;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_unexpected: wen=%b addr=%h, required no response",
                   rsp_fifo_wen, rsp_fifo_wdata[AW+DW-1:DW]);
        end else begin
          e = sb.pop_front();
          if (!$onehot(rsp_fifo_wen) || widx != e.idx ||
              rsp_fifo_wdata[AW+DW-1:DW] !== e.addr || rsp_fifo_wdata[DW-1:0] !== e.data) begin
            errors++;
            $display("[TB] FAIL rsp_data: got wen=%b addr=%h data=%h, required req=%0d addr=%h data=%h",
                     rsp_fifo_wen, rsp_fifo_wdata[AW+DW-1:DW], rsp_fifo_wdata[DW-1:0],
                     e.idx, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic loadFifo(input int i, input logic [AW-1:0] a);
    fmem[i][tail[i] % 64] = a;
    tail[i] = tail[i] + 1;
  endtask

  task automatic applyStimulus(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    loadFifo(i, a);
    e.idx  = i;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst     = 1'b1;
    cfg_wen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [AW-1:0] a;

    // Reset values
    resetDut();
    #2;
    checkOutput("reset_ren_wen", 160'({req_fifo_ren, rsp_fifo_wen}), 160'(6'b0));
    checkOutput("reset_tab", 160'({tab_en, tab_we, tab_addr}), 160'(14'b0));
    checkOutput("reset_tab_wdata", 160'(tab_wdata), 160'(0));
    checkOutput("reset_rsp_wdata", 160'(rsp_fifo_wdata), 160'(0));
    checkOutput("reset_wrdy", 160'(cfg_wrdy), 160'(1));
    checkOutput("reset_dbg", 160'(dbg_sig), 160'(0));

    // Single read from requester 1
    @(negedge clk);
    applyStimulus(1, 12'h05A, {16{8'hAB}});
    #2 checkOutput("single_ren_T", 160'(req_fifo_ren), 160'(3'b010));
    repeat (2) @(negedge clk);
    #2 checkOutput("single_tab_T2", 160'({tab_en, tab_we, tab_addr}), 160'({1'b1, 1'b0, 12'h05A}));
    repeat (2) @(negedge clk);
    #2 checkOutput("single_wen_T4", 160'(rsp_fifo_wen), 160'(3'b000));
    @(negedge clk);
    #2 checkOutput("single_wen_T5", 160'(rsp_fifo_wen), 160'(3'b010));
    waitDrain(20);

    // Fairness: all three requesters busy for nine grants
    resetDut();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) begin
        a = 12'h200 + 12'(16 * k + i);
        applyStimulus(i, a, pat(a));
      end
    for (int c = 0; c < 9; c++) begin
      #2 checkOutput("fair_grant", 160'(req_fifo_ren), 160'(3'b001 << (c % 3)));
      @(negedge clk);
    end
    #2 checkOutput("fair_dbg_reads", 160'(dbg_sig[15:0]), 160'(9));
    waitDrain(20);

    // Backpressure on requester 0
    @(negedge clk);
    rsp_fifo_nafull = 3'b110;
    applyStimulus(2, 12'h321, pat(12'h321));
    applyStimulus(2, 12'h322, pat(12'h322));
    applyStimulus(0, 12'h0A0, pat(12'h0A0));
    applyStimulus(0, 12'h0A1, pat(12'h0A1));
    #2 checkOutput("bp_grant0", 160'(req_fifo_ren), 160'(3'b100));
    @(negedge clk);
    #2 checkOutput("bp_grant1", 160'(req_fifo_ren), 160'(3'b100));
    @(negedge clk);
    #2 checkOutput("bp_hold0", 160'(req_fifo_ren), 160'(3'b000));
    @(negedge clk);
    #2 checkOutput("bp_hold1", 160'(req_fifo_ren), 160'(3'b000));
    @(negedge clk);
    rsp_fifo_nafull = 3'b111;
    #2 checkOutput("bp_resume0", 160'(req_fifo_ren), 160'(3'b001));
    @(negedge clk);
    #2 checkOutput("bp_resume1", 160'(req_fifo_ren), 160'(3'b001));
    waitDrain(20);

    // Write burst limit with requester 0 waiting
    @(negedge clk);
    cfg_wen   = 1'b1;
    cfg_waddr = 12'h300;
    cfg_wdata = 128'h1000;
    applyStimulus(0, 12'h010, pat(12'h010));
    applyStimulus(0, 12'h011, pat(12'h011));
    applyStimulus(0, 12'h012, pat(12'h012));
    for (int c = 0; c < 10; c++) begin
      #2;
      checkOutput("wl_wrdy", 160'(cfg_wrdy), 160'((c == 4 || c == 9) ? 1'b0 : 1'b1));
      checkOutput("wl_ren", 160'(req_fifo_ren), 160'((c == 4 || c == 9) ? 3'b001 : 3'b000));
      @(negedge clk);
      cfg_waddr = cfg_waddr + 12'd1;
      cfg_wdata = cfg_wdata + 128'd1;
    end
    cfg_wen = 1'b0;
    waitDrain(20);
    checkOutput("wl_dbg", 160'(dbg_sig), 160'({16'd8, 16'd16}));

    // Read-after-write in the following slot
    @(negedge clk);
    cfg_wen   = 1'b1;
    cfg_waddr = 12'h007;
    cfg_wdata = 128'h123;
    applyStimulus(0, 12'h007, 128'h123);
    #2 checkOutput("raw_write_slot", 160'({cfg_wrdy, req_fifo_ren}), 160'(4'b1000));
    @(negedge clk);
    cfg_wen = 1'b0;
    #2 checkOutput("raw_read_slot", 160'(req_fifo_ren), 160'(3'b001));
    waitDrain(20);

    // Reset in the middle of a read
    @(negedge clk);
    loadFifo(1, 12'h033);
    #2 checkOutput("rst_ren_T", 160'(req_fifo_ren), 160'(3'b010));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rst_outs", 160'({req_fifo_ren, rsp_fifo_wen, tab_en, tab_we, cfg_wrdy}), 160'(9'b000000001));
    checkOutput("rst_rsp_wdata", 160'(rsp_fifo_wdata), 160'(0));
    checkOutput("rst_dbg", 160'(dbg_sig), 160'(0));
    repeat (6) @(negedge clk);
    applyStimulus(0, 12'h044, pat(12'h044));
    applyStimulus(1, 12'h055, pat(12'h055));
    #2 checkOutput("rst_first_grant", 160'(req_fifo_ren), 160'(3'b001));
    waitDrain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
